vic_raster_gen: RTL and testbench

Parametrised raster timing and test-pattern generator. It is the successor to the fixed-timing sync generator plus grey-ramp colour path in the VIC-II top level. It generates programmable H/V timing with selectable sync polarity and a border/window split. Four pattern modes use a 16-entry C64 palette, with frame-synchronous register shadowing and a raster-line interrupt. It feeds the video DAC pins directly.

---
 rtl/vic_raster_gen.sv | 214 +++++++++++++++++++++
 tb/tb_vic_raster_gen.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vic_raster_gen.sv
// vic_raster_gen: programmable raster timing generator with a four-mode
// test pattern drawn from the 16-entry C64 palette. It has a frame-locked
// register shadow and a sticky raster-line interrupt. Every output is
// registered from the same (h,v) position, so the pins always describe one
// pixel, one clock after the counters reach it.
module vic_raster_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int HSYNC_POL = 0,
  parameter int VSYNC_POL = 0,
  parameter int BORDER_X  = 64,
  parameter int BORDER_Y  = 40,
  parameter int BAR_SHIFT = 5,
  parameter int COLOR_W   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         i_mode,
  input  logic [3:0]         i_border_color,
  input  logic [3:0]         i_bg_color,
  input  logic [9:0]         i_irq_line,
  input  logic               i_irq_ack,
  output logic               o_hsync,
  output logic               o_vsync,
  output logic               o_display_on,
  output logic [9:0]         o_hpos,
  output logic [9:0]         o_vpos,
  output logic [COLOR_W-1:0] o_red,
  output logic [COLOR_W-1:0] o_green,
  output logic [COLOR_W-1:0] o_blue,
  output logic               o_irq,
  output logic               o_frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // All position thresholds are held at counter width so compares stay exact.
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] WIN_X0   = 10'(BORDER_X);
  localparam logic [9:0] WIN_X1   = 10'(H_ACTIVE - BORDER_X);
  localparam logic [9:0] WIN_Y0   = 10'(BORDER_Y);
  localparam logic [9:0] WIN_Y1   = 10'(V_ACTIVE - BORDER_Y);

  localparam logic HS_ASSERT = 1'(HSYNC_POL);
  localparam logic VS_ASSERT = 1'(VSYNC_POL);

  // Colour registers that come out of reset before the first frame capture.
  localparam logic [1:0] RST_MODE   = 2'd0;
  localparam logic [3:0] RST_BORDER = 4'd14;
  localparam logic [3:0] RST_BG     = 4'd6;

  logic [9:0] h;
  logic [9:0] v;

  logic [1:0] mode_sh;
  logic [3:0] border_sh;
  logic [3:0] bg_sh;

  logic       frame_origin;
  logic [1:0] eff_mode;
  logic [3:0] eff_border;
  logic [3:0] eff_bg;
  logic       active;
  logic       in_window;
  logic       hs_on;
  logic       vs_on;
  logic [3:0] bar_idx;
  logic [3:0] pix_idx;
  logic [11:0] pix_rgb;
  logic       irq_hit;

  // C64 palette as packed R,G,B nibbles.
  function automatic logic [11:0] palette(input logic [3:0] idx);
    logic [11:0] rgb;
    case (idx)
      4'd0:    rgb = 12'h000;
      4'd1:    rgb = 12'hFFF;
      4'd2:    rgb = 12'h833;
      4'd3:    rgb = 12'h7CC;
      4'd4:    rgb = 12'h839;
      4'd5:    rgb = 12'h5A4;
      4'd6:    rgb = 12'h329;
      4'd7:    rgb = 12'hBC7;
      4'd8:    rgb = 12'h852;
      4'd9:    rgb = 12'h540;
      4'd10:   rgb = 12'hB66;
      4'd11:   rgb = 12'h444;
      4'd12:   rgb = 12'h777;
      4'd13:   rgb = 12'h9E8;
      4'd14:   rgb = 12'h76D;
      default: rgb = 12'hAAA;
    endcase
    return rgb;
  endfunction

  // Widen a nibble to the DAC width by repeating it and keeping the top bits.
  // COLOR_W above 8 is outside the supported range.
  function automatic logic [COLOR_W-1:0] expand(input logic [3:0] n);
    logic [COLOR_W-1:0] r;
    r = '0;
    for (int i = 0; i < COLOR_W; i++) begin
      r[COLOR_W-1-i] = n[3-(i%4)];
    end
    return r;
  endfunction

  // Free-running raster counters; a reset aborts the frame and restarts at (0,0).
  always_ff @(posedge clk) begin
    if (!reset) begin
      h <= '0;
      v <= '0;
    end else if (h == H_LAST) begin
      h <= '0;
      v <= (v == V_LAST) ? 10'd0 : v + 10'd1;
    end else begin
      h <= h + 10'd1;
    end
  end

  // Position decode, plus the colour settings that apply to the current pixel.
  // At the frame origin the inputs are being captured on this very edge, so
  // they are used directly and pixel (0,0) belongs to the new frame.
  always_comb begin
    frame_origin = (h == 10'd0) && (v == 10'd0);
    eff_mode     = frame_origin ? i_mode         : mode_sh;
    eff_border   = frame_origin ? i_border_color : border_sh;
    eff_bg       = frame_origin ? i_bg_color     : bg_sh;
    active       = (h < H_ACT) && (v < V_ACT);
    in_window    = (h >= WIN_X0) && (h < WIN_X1) && (v >= WIN_Y0) && (v < WIN_Y1);
    hs_on        = (h >= HS_START) && (h < HS_END);
    vs_on        = (v >= VS_START) && (v < VS_END);
    bar_idx      = 4'((h - WIN_X0) >> BAR_SHIFT);
    irq_hit      = (h == 10'd0) && (v == i_irq_line);
  end

  // Palette index selection: border outside the window, pattern inside it.
  always_comb begin
    pix_idx = eff_border;
    if (in_window) begin
      case (eff_mode)
        2'd0:    pix_idx = eff_bg;
        2'd1:    pix_idx = bar_idx;
        2'd2:    pix_idx = v[3:0];
        default: pix_idx = (h[3] ^ v[3]) ? eff_border : eff_bg;
      endcase
    end
    pix_rgb = palette(pix_idx);
  end

  // Frame-locked shadow of the colour and mode inputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mode_sh   <= RST_MODE;
      border_sh <= RST_BORDER;
      bg_sh     <= RST_BG;
    end else if (frame_origin) begin
      mode_sh   <= i_mode;
      border_sh <= i_border_color;
      bg_sh     <= i_bg_color;
    end
  end

  // Registered video outputs, all describing the pixel at the current (h,v).
  always_ff @(posedge clk) begin
    if (!reset) begin
      o_hsync       <= ~HS_ASSERT;
      o_vsync       <= ~VS_ASSERT;
      o_display_on  <= 1'b0;
      o_hpos        <= '0;
      o_vpos        <= '0;
      o_red         <= '0;
      o_green       <= '0;
      o_blue        <= '0;
      o_frame_start <= 1'b0;
    end else begin
      o_hsync       <= hs_on ? HS_ASSERT : ~HS_ASSERT;
      o_vsync       <= vs_on ? VS_ASSERT : ~VS_ASSERT;
      o_display_on  <= active;
      o_hpos        <= h;
      o_vpos        <= v;
      o_red         <= active ? expand(pix_rgb[11:8]) : '0;
      o_green       <= active ? expand(pix_rgb[7:4])  : '0;
      o_blue        <= active ? expand(pix_rgb[3:0])  : '0;
      o_frame_start <= frame_origin;
    end
  end

  // Sticky raster interrupt; a new hit takes priority over an acknowledge.
  // Lines beyond the frame never match because v never reaches them.
  always_ff @(posedge clk) begin
    if (!reset) begin
      o_irq <= 1'b0;
    end else if (irq_hit) begin
      o_irq <= 1'b1;
    end else if (i_irq_ack) begin
      o_irq <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vic_raster_gen.sv
// tb_vic_raster_gen: directed bench for vic_raster_gen with a reduced raster
// so several whole frames fit in a short run. A position-from-cycle-count
// model predicts every output each cycle, and literal checks pin the model.
module tb_vic_raster_gen;

  localparam int HA = 128, HFP = 8, HSW = 16, HBP = 8;
  localparam int VA = 96,  VFP = 3, VSW = 2,  VBP = 5;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int BX = 16, BY = 8, BS = 2;

  localparam logic [11:0] PAL [16] = '{
    12'h000, 12'hFFF, 12'h833, 12'h7CC,
    12'h839, 12'h5A4, 12'h329, 12'hBC7,
    12'h852, 12'h540, 12'hB66, 12'h444,
    12'h777, 12'h9E8, 12'h76D, 12'hAAA
  };

  logic       clk;
  logic       reset;
  logic [1:0] i_mode;
  logic [3:0] i_border_color;
  logic [3:0] i_bg_color;
  logic [9:0] i_irq_line;
  logic       i_irq_ack;
  logic       o_hsync, o_vsync, o_display_on, o_irq, o_frame_start;
  logic [9:0] o_hpos, o_vpos;
  logic [7:0] o_red, o_green, o_blue;

  vic_raster_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HSYNC_POL(1), .VSYNC_POL(0),
    .BORDER_X(BX), .BORDER_Y(BY), .BAR_SHIFT(BS), .COLOR_W(8)
  ) dut (
    .clk(clk), .reset(reset),
    .i_mode(i_mode), .i_border_color(i_border_color), .i_bg_color(i_bg_color),
    .i_irq_line(i_irq_line), .i_irq_ack(i_irq_ack),
    .o_hsync(o_hsync), .o_vsync(o_vsync), .o_display_on(o_display_on),
    .o_hpos(o_hpos), .o_vpos(o_vpos),
    .o_red(o_red), .o_green(o_green), .o_blue(o_blue),
    .o_irq(o_irq), .o_frame_start(o_frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nCompared = 0;
  int nMismatched = 0;
  int cycleNo = 0;
  int lastFs = -1;
  int fsPeriod = 0;

  // Model state: pixels since reset release and the frame's captured settings.
  int         mCount;
  logic [1:0] mMode;
  logic [3:0] mBorder, mBg;
  logic       mIrq;
  logic       eHs, eVs, eDe, eFs;
  int         eH, eV;
  logic [7:0] eR, eG, eB;

  // Advance the model by one clock edge using the inputs seen at that edge.
  task automatic updateModel();
    int h, v;
    logic [3:0] idx;
    logic [11:0] c;
    if (!reset) begin
      mCount = 0; mMode = 2'd0; mBorder = 4'd14; mBg = 4'd6; mIrq = 1'b0;
      eHs = 1'b0; eVs = 1'b1; eDe = 1'b0; eFs = 1'b0;
      eH = 0; eV = 0; eR = 8'h00; eG = 8'h00; eB = 8'h00;
    end else begin
      h = mCount % HT;
      v = (mCount / HT) % VT;
      if (h == 0 && v == 0) begin
        mMode = i_mode; mBorder = i_border_color; mBg = i_bg_color;
      end
      eH = h; eV = v;
      eFs = (h == 0 && v == 0);
      eDe = (h < HA) && (v < VA);
      eHs = (h >= HA + HFP) && (h < HA + HFP + HSW);
      eVs = !((v >= VA + VFP) && (v < VA + VFP + VSW));
      idx = mBorder;
      if (h >= BX && h < HA - BX && v >= BY && v < VA - BY) begin
        case (mMode)
          2'd0: idx = mBg;
          2'd1: idx = 4'(((h - BX) >> BS) % 16);
          2'd2: idx = 4'(v % 16);
          default: idx = (((h ^ v) >> 3) & 1) != 0 ? mBorder : mBg;
        endcase
      end
      c = PAL[idx];
      eR = eDe ? {c[11:8], c[11:8]} : 8'h00;
      eG = eDe ? {c[7:4], c[7:4]} : 8'h00;
      eB = eDe ? {c[3:0], c[3:0]} : 8'h00;
      if (h == 0 && v == int'(i_irq_line)) mIrq = 1'b1;
      else if (i_irq_ack) mIrq = 1'b0;
      mCount++;
    end
  endtask

  // Whole-output comparison against the model for the pixel now on the pins.
  task automatic checkOutput();
    logic [48:0] act, exp;
    act = {o_hsync, o_vsync, o_display_on, o_hpos, o_vpos, o_red, o_green, o_blue, o_irq, o_frame_start};
    exp = {eHs, eVs, eDe, 10'(eH), 10'(eV), eR, eG, eB, mIrq, eFs};
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL model cycle %0d: got hs=%b vs=%b de=%b pos=(%0d,%0d) rgb=%h%h%h irq=%b fs=%b, want hs=%b vs=%b de=%b pos=(%0d,%0d) rgb=%h%h%h irq=%b fs=%b",
               cycleNo, o_hsync, o_vsync, o_display_on, o_hpos, o_vpos, o_red, o_green, o_blue, o_irq, o_frame_start,
               eHs, eVs, eDe, eH, eV, eR, eG, eB, mIrq, eFs);
    end
  endtask

  task automatic checkLiteral(input string name, input int act, input int exp);
    nCompared++;
    if (act != exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] mode, input logic [3:0] border,
                               input logic [3:0] bg, input logic [9:0] line,
                               input logic ack);
    i_mode = mode; i_border_color = border; i_bg_color = bg;
    i_irq_line = line; i_irq_ack = ack;
  endtask

  // One clock: model and DUT both see the edge, outputs checked on the falling edge.
  task automatic stepCycle();
    @(posedge clk);
    updateModel();
    @(negedge clk);
    cycleNo++;
    if (o_frame_start) begin
      if (lastFs >= 0) fsPeriod = cycleNo - lastFs;
      lastFs = cycleNo;
    end
    checkOutput();
  endtask

  // Step until the model says pixel (x,y) is on the outputs, within a bound.
  task automatic runTo(input int x, input int y);
    int n;
    n = 0;
    while (!(eH == x && eV == y && reset) && n < 20000) begin
      stepCycle();
      n++;
    end
    if (n >= 20000) begin
      nMismatched++;
      $display("[TB] FAIL runTo(%0d,%0d): position not reached within %0d cycles", x, y, n);
    end
  endtask

  initial begin
    reset = 1'b0;
    applyStimulus(2'd0, 4'd14, 4'd6, 10'd600, 1'b0);
    repeat (5) stepCycle();
    checkLiteral("reset_hsync", int'(o_hsync), 0);
    checkLiteral("reset_vsync", int'(o_vsync), 1);
    checkLiteral("reset_de", int'(o_display_on), 0);
    checkLiteral("reset_red", int'(o_red), 0);

    reset = 1'b1;
    stepCycle();
    checkLiteral("first_hpos", int'(o_hpos), 0);
    checkLiteral("first_vpos", int'(o_vpos), 0);
    checkLiteral("first_fs", int'(o_frame_start), 1);
    checkLiteral("first_de", int'(o_display_on), 1);
    checkLiteral("first_hsync", int'(o_hsync), 0);
    checkLiteral("first_vsync", int'(o_vsync), 1);
    checkLiteral("first_red", int'(o_red), 8'h77);

    // Frame 1: mode 0 defaults, timing edges.
    runTo(5, 5);
    checkLiteral("border_rgb", int'({o_red, o_green, o_blue}), 24'h7766DD);
    runTo(135, 5);
    checkLiteral("hsync_before", int'(o_hsync), 0);
    stepCycle();
    checkLiteral("hsync_start", int'(o_hsync), 1);
    runTo(140, 5);
    checkLiteral("blank_rgb", int'({o_red, o_green, o_blue}), 0);
    checkLiteral("blank_de", int'(o_display_on), 0);
    runTo(151, 5);
    checkLiteral("hsync_last", int'(o_hsync), 1);
    stepCycle();
    checkLiteral("hsync_end", int'(o_hsync), 0);
    runTo(50, 50);
    checkLiteral("bg_rgb", int'({o_red, o_green, o_blue}), 24'h332299);
    runTo(0, 98);
    checkLiteral("vsync_before", int'(o_vsync), 1);
    runTo(0, 99);
    checkLiteral("vsync_start", int'(o_vsync), 0);
    runTo(159, 100);
    checkLiteral("vsync_last", int'(o_vsync), 0);
    runTo(0, 101);
    checkLiteral("vsync_end", int'(o_vsync), 1);
    checkLiteral("irq_line600", int'(o_irq), 0);
    applyStimulus(2'd1, 4'd14, 4'd6, 10'd30, 1'b0);

    // Frame 2: colour bars, interrupt set/ack, mid-frame mode change.
    runTo(0, 0);
    checkLiteral("frame_period", fsPeriod, HT * VT);
    runTo(159, 29);
    checkLiteral("irq_before", int'(o_irq), 0);
    runTo(0, 30);
    checkLiteral("irq_set", int'(o_irq), 1);
    runTo(4, 30);
    applyStimulus(2'd1, 4'd14, 4'd6, 10'd30, 1'b1);
    stepCycle();
    applyStimulus(2'd1, 4'd14, 4'd6, 10'd30, 1'b0);
    checkLiteral("irq_ack", int'(o_irq), 0);
    runTo(20, 50);
    checkLiteral("bar1_rgb", int'({o_red, o_green, o_blue}), 24'hFFFFFF);
    runTo(76, 50);
    checkLiteral("bar15_rgb", int'({o_red, o_green, o_blue}), 24'hAAAAAA);
    runTo(80, 50);
    checkLiteral("bar_wrap_rgb", int'({o_red, o_green, o_blue}), 0);
    runTo(0, 60);
    applyStimulus(2'd2, 4'd14, 4'd6, 10'd30, 1'b0);
    runTo(20, 70);
    checkLiteral("shadow_hold", int'({o_red, o_green, o_blue}), 24'hFFFFFF);
    runTo(0, 80);
    applyStimulus(2'd2, 4'd14, 4'd6, 10'd90, 1'b0);
    runTo(159, 89);
    applyStimulus(2'd2, 4'd14, 4'd6, 10'd90, 1'b1);
    stepCycle();
    applyStimulus(2'd2, 4'd14, 4'd6, 10'd90, 1'b0);
    checkLiteral("irq_set_wins", int'(o_irq), 1);
    stepCycle();
    checkLiteral("irq_stays", int'(o_irq), 1);
    runTo(0, 95);
    applyStimulus(2'd2, 4'd14, 4'd6, 10'(VT), 1'b1);
    stepCycle();
    applyStimulus(2'd2, 4'd14, 4'd6, 10'(VT), 1'b0);
    checkLiteral("irq_cleared", int'(o_irq), 0);

    // Frame 3: mode 2 takes effect, reset mid-frame, out-of-range IRQ line.
    runTo(20, 70);
    checkLiteral("mode2_rgb", int'({o_red, o_green, o_blue}), 24'h332299);
    runTo(60, 80);
    reset = 1'b0;
    stepCycle();
    checkLiteral("midreset_de", int'(o_display_on), 0);
    reset = 1'b1;
    stepCycle();
    checkLiteral("restart_hpos", int'(o_hpos), 0);
    checkLiteral("restart_vpos", int'(o_vpos), 0);
    checkLiteral("restart_fs", int'(o_frame_start), 1);
    runTo(100, 105);
    checkLiteral("irq_out_of_range", int'(o_irq), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
